div_ctrl: RTL and testbench
===========================

# div_ctrl

Multi-cycle divide controller and datapath for the HI/LO unit. It is instantiated in the execute stage and sequences a radix-2 restoring division for DIV/DIVU. It produces a 64-bit {remainder, quotient} result for the HI/LO write path, plus the done/busy handshake from which the execute stage derives its stall. It holds the result until the downstream pipeline releases, and aborts cleanly on flush.

## Interface
- No parameters; iteration count fixed at 32.
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  level request; high while the EX instruction is DIV/DIVU
- flag_unsigned  input  1  1 = DIVU, 0 = DIV; sampled with start
- operand1  input  32  dividend (rs)
- operand2  input  32  divisor (rt)
- stall_i  input  1  downstream hold; EX cannot advance while high
- cancel  input  1  flush/exception; abort current operation
- result  output  64  {remainder[63:32] → HI, quotient[31:0] → LO}
- done  output  1  result valid; high only in DONE state
- busy  output  1  high in ITER and FIX

## Operation
- States: IDLE, ITER, FIX, DONE; 5-bit iteration counter.
- IDLE:
  - start=1 and cancel=0 → capture |operand1|, |operand2|, the sign flags and the unsigned flag; clear the partial remainder; counter=0; go to ITER.
  - For DIVU, or for non-negative operands, the magnitude equals the operand.
  - |−2^31| = 0x80000000, treated as unsigned.
- ITER: one restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - Trial subtract the divisor from the 33-bit remainder.
  - If non-negative, keep the difference and set the quotient LSB.
  - counter+1; after the 32nd step (counter==31) go to FIX.
- FIX: apply signs and write the result register.
  - Quotient is negated iff DIV and the operand signs differ.
  - Remainder is negated iff DIV and the dividend is negative.
  - Arithmetic is modulo 2^32: −2^31 / −1 gives quotient 0x80000000, remainder 0.
  - Then go to DONE.
- Divide by zero (captured divisor == 0): iterations still run; FIX forces result = {operand1 as captured, 0xFFFFFFFF}, independent of the signs.
- DONE: done=1, result stable.
  - stall_i=1 → stay in DONE.
  - stall_i=0 → go to IDLE.
  - If start is still high in the following IDLE cycle, it is a new instruction and starts a new division.
- cancel=1 in any state → IDLE at the next edge; result unchanged; done/busy low from the next cycle. cancel beats start in IDLE.
- Operand or flag changes after capture are ignored until the next IDLE.

## Timing
- Reset: state IDLE, counter 0, result 0, done 0, busy 0; internal registers 0.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- Cycle 0 = the IDLE cycle with start=1. Cycles 1–32 are ITER, cycle 33 is FIX, and cycle 34 is DONE (done=1).
- Latency is 34 cycles from start to done, independent of operand values, signedness and zero divisor.
- EX stall equals start & ~done; in cycle 0 it is high because done=0.
- Back-to-back divides: start high in the cycle after DONE (stall_i=0) begins the next operation. There are no idle bubbles beyond that IDLE cycle.
- DONE with stall_i held high for N cycles → done stays high N+1 cycles and result is constant.
- Reset asserted mid-operation forces the reset values immediately (asynchronous) and holds them while asserted.

## Structure
- Shared package / defines header holds:
  - state encodings DIV_IDLE, DIV_ITER, DIV_FIX, DIV_DONE (2-bit);
  - constant DIV_ITERS=32;
  - result field positions (HI = [63:32], LO = [31:0]).
- One natural sub-module: div_step, a combinational single restoring iteration.
  - Inputs: 33-bit remainder, 32-bit quotient, 32-bit divisor.
  - Outputs: next remainder, next quotient.
  - Instantiated once, inside the ITER datapath.
- The remaining logic is the FSM, counter, operand capture and sign fixup, in div_ctrl itself.

## Test plan
- DIVU 100/7: start with operands 0x64, 0x7 → done in cycle 34, result={0x2, 0xE}; busy high cycles 1–33.
- DIV −7/2: operands 0xFFFFFFF9, 0x2 → result={0xFFFFFFFF, 0xFFFFFFFD}. DIV 0x80000000/0xFFFFFFFF → {0x0, 0x80000000}.
- Divide by zero: DIV 0x12345678/0 → result={0x12345678, 0xFFFFFFFF} at cycle 34.
- Cancel at cycle 10: state IDLE at the next edge, done never asserts, result keeps its previous value. Start with cancel in the same cycle → no operation starts.
- DONE hold and back-to-back: stall_i high 3 cycles in DONE → done high 4 cycles with stable result. Second start immediately after → its done arrives 34 cycles after its own start cycle.
- Async reset asserted at cycle 20 mid-iteration → all outputs 0 immediately. After release, a fresh DIVU 9/3 gives {0x0, 0x3}.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the HI/LO divide controller: FSM encodings, iteration
// count, result field positions and the operand magnitude helper.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ITER = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_t;

  localparam int         DIV_ITERS = 32;
  localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

  localparam int HI_MSB = 63;
  localparam int HI_LSB = 32;
  localparam int LO_MSB = 31;
  localparam int LO_LSB = 0;

  // Two's-complement magnitude; 0x80000000 maps to itself and is read as unsigned.
  function automatic logic [31:0] magnitude(input logic [31:0] value, input logic neg);
    return neg ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem, quo} left, trial-subtract the
// divisor, keep the difference and set the quotient LSB when it fits.
module div_step (
  input  logic [32:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] divisor,
  output logic [32:0] rem_next,
  output logic [31:0] quo_next
);

  logic [32:0] shifted;
  logic [32:0] diff;
  logic        fits;

  assign shifted = {rem[31:0], quo[31]};
  assign diff    = shifted - {1'b0, divisor};
  // The partial remainder stays below the divisor, so diff[32] is the borrow;
  // a set carry bit in the incoming remainder would always fit.
  assign fits    = rem[32] | ~diff[32];

  assign rem_next = fits ? diff : shifted;
  assign quo_next = {quo[30:0], fits};

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer for the HI/LO unit: captures operand magnitudes,
// runs 32 restoring steps, applies signs and holds {rem, quo} until released.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flag_unsigned,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic        stall_i,
  input  logic        cancel,
  output logic [63:0] result,
  output logic        done,
  output logic        busy
);

  div_state_t  state, state_next;
  logic [4:0]  count;
  logic [32:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] divisor_q;
  logic [31:0] dividend_q;
  logic        neg_dividend_q;
  logic        neg_divisor_q;
  logic        unsigned_q;
  logic [63:0] result_q;

  logic [32:0] rem_step;
  logic [31:0] quo_step;
  logic [63:0] fix_result;
  logic        neg_quo;
  logic        neg_rem;

  div_step u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (divisor_q),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    if (cancel) begin
      state_next = DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: if (start)              state_next = DIV_ITER;
        DIV_ITER: if (count == LAST_ITER) state_next = DIV_FIX;
        DIV_FIX:                          state_next = DIV_DONE;
        DIV_DONE: if (!stall_i)           state_next = DIV_IDLE;
        default:                          state_next = DIV_IDLE;
      endcase
    end
  end

  always_comb begin
    neg_quo    = ~unsigned_q & (neg_dividend_q ^ neg_divisor_q);
    neg_rem    = ~unsigned_q & neg_dividend_q;
    fix_result = '0;
    if (divisor_q == 32'd0) begin
      fix_result[HI_MSB:HI_LSB] = dividend_q;
      fix_result[LO_MSB:LO_LSB] = 32'hFFFF_FFFF;
    end else begin
      fix_result[HI_MSB:HI_LSB] = magnitude(rem_q[31:0], neg_rem);
      fix_result[LO_MSB:LO_LSB] = magnitude(quo_q, neg_quo);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: the datapath registers are few and hold architecturally visible
  // values, so all of them are reset rather than left undefined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count          <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      divisor_q      <= '0;
      dividend_q     <= '0;
      neg_dividend_q <= 1'b0;
      neg_divisor_q  <= 1'b0;
      unsigned_q     <= 1'b0;
      result_q       <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start && !cancel) begin
            count          <= '0;
            rem_q          <= '0;
            quo_q          <= magnitude(operand1, ~flag_unsigned & operand1[31]);
            divisor_q      <= magnitude(operand2, ~flag_unsigned & operand2[31]);
            dividend_q     <= operand1;
            neg_dividend_q <= operand1[31];
            neg_divisor_q  <= operand2[31];
            unsigned_q     <= flag_unsigned;
          end
        end
        DIV_ITER: begin
          rem_q <= rem_step;
          quo_q <= quo_step;
          count <= count + 5'd1;
        end
        DIV_FIX: begin
          // A flush in the fixup cycle must leave the previous result visible.
          if (!cancel) result_q <= fix_result;
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign done   = (state == DIV_DONE);
  assign busy   = (state == DIV_ITER) || (state == DIV_FIX);

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed corner cases plus random DIV/DIVU
// traffic, scored against an arithmetic reference through an expectation queue.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flag_unsigned;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        stall_i;
  logic        cancel;
  logic [63:0] result;
  logic        done;
  logic        busy;

  div_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .flag_unsigned (flag_unsigned),
    .operand1      (operand1),
    .operand2      (operand2),
    .stall_i       (stall_i),
    .cancel        (cancel),
    .result        (result),
    .done          (done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          due;
    int          hold;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  // Reference: plain integer division, truncating toward zero for DIV.
  function automatic logic [63:0] model(input logic u, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    sa = u ? longint'(a) : longint'($signed(a));
    sb = u ? longint'(b) : longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops an expectation on every rising done and follows the hold window.
  initial begin : monitor
    logic done_d = 1'b0;
    bit   active = 1'b0;
    int   hi_cnt = 0;
    exp_t cur;
    forever begin
      @(negedge clk);
      if (done && !done_d) begin
        hi_cnt = 1;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          active = 1'b0;
          $display("FAIL unexpected_done @cyc %0d: result %h with nothing outstanding", cyc, result);
        end else begin
          cur    = exp_q.pop_front();
          active = 1'b1;
          check("result", result, cur.res);
          check("latency_cycle", 64'(cyc), 64'(cur.due));
        end
      end else if (done && done_d) begin
        hi_cnt++;
        if (active) check("result_hold", result, cur.res);
      end else if (!done && done_d && active) begin
        check("done_width", 64'(hi_cnt), 64'(cur.hold + 1));
        active = 1'b0;
      end
      done_d = done;
    end
  end

  // Called mid-cycle with the DUT in IDLE; this cycle becomes cycle 0.
  task automatic issue(input logic u, input logic [31:0] a, input logic [31:0] b, input int hold);
    exp_t e;
    check("c0_busy", 64'(busy), 64'(0));
    check("c0_done", 64'(done), 64'(0));
    start         = 1'b1;
    flag_unsigned = u;
    operand1      = a;
    operand2      = b;
    e.res  = model(u, a, b);
    e.due  = cyc + 34;
    e.hold = hold;
    exp_q.push_back(e);
  endtask

  // Walks cycles 1..34, then releases DONE after `hold` stalled cycles.
  task automatic run(input int hold);
    for (int i = 1; i <= 34; i++) begin
      @(posedge clk);
      #1;
      flag_unsigned = 1'($urandom);
      operand1      = $urandom;
      operand2      = $urandom;
      check($sformatf("busy_c%0d", i), 64'(busy), 64'(i <= 33));
      check($sformatf("done_c%0d", i), 64'(done), 64'(i == 34));
    end
    stall_i = (hold > 0);
    repeat (hold) @(posedge clk);
    #1;
    stall_i = 1'b0;
    @(posedge clk);
    #1;
    check("release_done", 64'(done), 64'(0));
  endtask

  task automatic do_div(input logic u, input logic [31:0] a, input logic [31:0] b, input int hold);
    issue(u, a, b, hold);
    run(hold);
  endtask

  initial begin : timeout
    #500000;
    $display("FAIL timeout: simulation did not finish at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [63:0] prev;
    rst           = 1'b1;
    start         = 1'b0;
    flag_unsigned = 1'b0;
    operand1      = '0;
    operand2      = '0;
    stall_i       = 1'b0;
    cancel        = 1'b0;
    #1;
    check("rst_result", result, 64'd0);
    check("rst_done", 64'(done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_div(1'b1, 32'd100, 32'd7, 0);
    check("divu_100_7", result, 64'h0000_0002_0000_000E);
    do_div(1'b0, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_m7_2", result, 64'hFFFF_FFFF_FFFF_FFFD);
    do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 3);
    check("div_min_m1", result, 64'h0000_0000_8000_0000);
    do_div(1'b0, 32'h1234_5678, 32'd0, 0);
    check("div_by_zero", result, 64'h1234_5678_FFFF_FFFF);
    start = 1'b0;
    @(posedge clk);
    #1;

    // Flush in cycle 10 of an operation.
    prev     = result;
    start    = 1'b1;
    operand1 = 32'd1000;
    operand2 = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    start  = 1'b0;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    check("cancel_busy", 64'(busy), 64'(0));
    check("cancel_done", 64'(done), 64'(0));
    check("cancel_result", result, prev);
    repeat (40) @(posedge clk);
    #1;
    check("cancel_result_late", result, prev);

    // Cancel wins over start in IDLE.
    start  = 1'b1;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    cancel = 1'b0;
    check("start_cancel_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    check("start_cancel_busy2", 64'(busy), 64'(0));

    // Asynchronous reset in cycle 20.
    start         = 1'b1;
    flag_unsigned = 1'b1;
    operand1      = 32'hDEAD_BEEF;
    operand2      = 32'd5;
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_result", result, 64'd0);
    check("arst_done", 64'(done), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("arst_hold_result", result, 64'd0);
    check("arst_hold_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_div(1'b1, 32'd9, 32'd3, 0);
    check("divu_9_3", result, 64'h0000_0000_0000_0003);

    // Random traffic: mostly back-to-back, occasional idle gaps and stalls.
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        start = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      do_div(1'($urandom), rand_op(), rand_op(), $urandom_range(0, 3));
    end
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
